// File: rtl/chparam_prefetch.sv
// rtl/chparam_prefetch.sv - per-channel bias/quant parameter prefetcher with ping-pong buffer
// Fetches NC (or one broadcast) bias/quant words per group while the consumer works on the other buffer.
module chparam_prefetch #(
  parameter int NC = 4,
  parameter int AW = 12
) (
  input  logic               aclk,
  input  logic               arst_n,
  input  logic               grp_req,
  input  logic [AW-1:0]      grp_ch,
  input  logic               pt_mode,
  output logic               grp_ack,
  input  logic               flush,
  output logic [31:0]        d_adr,
  output logic               d_re,
  input  logic               d_rdy,
  input  logic [31:0]        d_dr,
  output logic [31:0]        e_adr,
  output logic               e_re,
  input  logic               e_rdy,
  input  logic [31:0]        e_dr,
  output logic               prm_valid,
  output logic [NC*32-1:0]   prm_bias,
  output logic [NC*32-1:0]   prm_quant,
  input  logic               prm_release,
  output logic               busy
);

  localparam int IW = (NC > 1) ? $clog2(NC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LAST} state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d, last_idx;
  logic [AW-1:0]             base_q, base_d, ch_addr;
  logic                      mode_q, mode_d;
  logic                      wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [1:0]                full_q, full_d;
  logic [1:0][NC-1:0][31:0]  bias_q, bias_d, quant_q, quant_d;
  logic                      jr, accept, release_ok;

  assign jr         = d_rdy & e_rdy;
  assign accept     = arst_n & ~flush & grp_req & (state_q == S_IDLE) & ~full_q[wr_sel_q];
  assign release_ok = prm_release & full_q[rd_sel_q];
  assign last_idx   = mode_q ? '0 : IW'(NC - 1);
  assign ch_addr    = base_q + AW'(idx_q);

  always_ff @(posedge aclk) begin
    if (!arst_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept) state_d = S_ISSUE;
        S_ISSUE: if (jr && idx_q == last_idx) state_d = S_LAST;
        S_LAST:  if (jr) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    grp_ack = accept;
    busy    = (state_q != S_IDLE);
    d_re    = busy;
    e_re    = busy;
    d_adr   = busy ? 32'({ch_addr, 2'b00}) : 32'd0;
    e_adr   = d_adr;
  end

  // Read data lags the address by one jr cycle, so ISSUE writes lane idx-1 and LAST writes lane idx.
  always_comb begin
    idx_d    = idx_q;
    base_d   = base_q;
    mode_d   = mode_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    full_d   = full_q;
    bias_d   = bias_q;
    quant_d  = quant_q;
    if (flush) begin
      full_d   = '0;
      wr_sel_d = 1'b0;
      rd_sel_d = 1'b0;
    end else begin
      if (release_ok) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
      end
      case (state_q)
        S_IDLE: if (accept) begin
          base_d = grp_ch;
          mode_d = pt_mode;
          idx_d  = '0;
        end
        S_ISSUE: if (jr) begin
          if (idx_q != '0) begin
            bias_d[wr_sel_q][idx_q - IW'(1)]  = d_dr;
            quant_d[wr_sel_q][idx_q - IW'(1)] = e_dr;
          end
          if (idx_q != last_idx) idx_d = idx_q + IW'(1);
        end
        S_LAST: if (jr) begin
          for (int k = 0; k < NC; k++) begin
            if (mode_q || IW'(k) == idx_q) begin
              bias_d[wr_sel_q][k]  = d_dr;
              quant_d[wr_sel_q][k] = e_dr;
            end
          end
          full_d[wr_sel_q] = 1'b1;
          wr_sel_d         = ~wr_sel_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      idx_q    <= '0;
      base_q   <= '0;
      mode_q   <= 1'b0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      full_q   <= '0;
      bias_q   <= '0;
      quant_q  <= '0;
    end else begin
      idx_q    <= idx_d;
      base_q   <= base_d;
      mode_q   <= mode_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      full_q   <= full_d;
      bias_q   <= bias_d;
      quant_q  <= quant_d;
    end
  end

  assign prm_valid = full_q[rd_sel_q];
  assign prm_bias  = bias_q[rd_sel_q];
  assign prm_quant = quant_q[rd_sel_q];

endmodule

// File: tb/tb_chparam_prefetch.sv
// tb/tb_chparam_prefetch.sv - scoreboard bench for chparam_prefetch
// Word-addressed cache model returns 0x1000+i / 0x20000+i one jr cycle after the address.
module tb_chparam_prefetch;
  localparam int NC = 4;
  localparam int AW = 12;

  logic             aclk, arst_n, grp_req, pt_mode, grp_ack, flush;
  logic [AW-1:0]    grp_ch;
  logic [31:0]      d_adr, d_dr, e_adr, e_dr;
  logic             d_re, d_rdy, e_re, e_rdy;
  logic             prm_valid, prm_release, busy;
  logic [NC*32-1:0] prm_bias, prm_quant;

  chparam_prefetch #(.NC(NC), .AW(AW)) dut (
    .aclk(aclk), .arst_n(arst_n), .grp_req(grp_req), .grp_ch(grp_ch), .pt_mode(pt_mode),
    .grp_ack(grp_ack), .flush(flush), .d_adr(d_adr), .d_re(d_re), .d_rdy(d_rdy), .d_dr(d_dr),
    .e_adr(e_adr), .e_re(e_re), .e_rdy(e_rdy), .e_dr(e_dr), .prm_valid(prm_valid),
    .prm_bias(prm_bias), .prm_quant(prm_quant), .prm_release(prm_release), .busy(busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [NC*32-1:0] b;
    logic [NC*32-1:0] q;
  } grp_t;

  grp_t        exp_q[$];
  logic [31:0] adr_log[$];
  int          checks = 0;
  int          errors = 0;
  bit          front_checked = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, expv);
    end
  endtask

  function automatic grp_t mk(input int ch, input bit pt);
    grp_t g;
    int   w;
    for (int k = 0; k < NC; k++) begin
      w = pt ? (ch % 4096) : ((ch + k) % 4096);
      g.b[32*k +: 32] = 32'h1000 + 32'(w);
      g.q[32*k +: 32] = 32'h20000 + 32'(w);
    end
    return g;
  endfunction

  // cache model
  initial begin
    d_dr = '0;
    e_dr = '0;
    forever begin
      @(posedge aclk);
      if (d_rdy && e_rdy) begin
        d_dr <= 32'h1000 + (d_adr >> 2);
        e_dr <= 32'h20000 + (e_adr >> 2);
      end
    end
  end

  // address log of every accepted read cycle
  initial begin
    forever begin
      @(negedge aclk);
      #2;
      if (d_re && d_rdy && e_rdy) begin
        adr_log.push_back(d_adr);
        chk("e_adr_eq_d_adr", e_adr, d_adr);
      end
    end
  end

  // scoreboard monitor: each new front buffer is compared once against the queue head
  initial begin
    bit   rel, rs;
    grp_t g;
    forever begin
      @(posedge aclk);
      rel = prm_valid && prm_release;
      rs  = !arst_n || flush;
      @(negedge aclk);
      if (rs) begin
        front_checked = 0;
        exp_q.delete();
      end else if (rel) begin
        front_checked = 0;
      end
      if (prm_valid && !front_checked) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_group got bias %0h expected none", prm_bias);
        end else begin
          g = exp_q.pop_front();
          chk("grp_bias", prm_bias, g.b);
          chk("grp_quant", prm_quant, g.q);
        end
        front_checked = 1;
      end
    end
  end

  task automatic req(input int ch, input bit pt, input int maxc, output bit acked);
    acked   = 0;
    grp_req = 1'b1;
    grp_ch  = ch[AW-1:0];
    pt_mode = pt;
    for (int n = 0; n < maxc && !acked; n++) begin
      #1;
      if (grp_ack) acked = 1;
      else @(negedge aclk);
    end
    if (acked) begin
      @(negedge aclk);
      grp_req = 1'b0;
    end
  endtask

  // called one negedge after the ack; returns cycles from ack to prm_valid
  task automatic wait_valid(input bit stall, input int maxn, output int n);
    n = 1;
    forever begin
      e_rdy = !(stall && (n == 2 || n == 4 || n == 5));
      if (prm_valid || n >= maxn) break;
      @(negedge aclk);
      n++;
    end
    e_rdy = 1'b1;
  endtask

  task automatic release_one();
    int n = 0;
    while (!prm_valid && n < 30) begin
      @(negedge aclk);
      n++;
    end
    chk("release_wait_valid", prm_valid, 1);
    prm_release = 1'b1;
    @(negedge aclk);
    prm_release = 1'b0;
  endtask

  task automatic chk_adrs(input string nm, input logic [31:0] a0, a1, a2, a3, a4, input int cnt);
    logic [31:0] ea[5];
    ea = '{a0, a1, a2, a3, a4};
    chk({nm, "_count"}, adr_log.size(), cnt);
    for (int i = 0; i < cnt; i++)
      chk(nm, (i < adr_log.size()) ? adr_log[i] : 32'hxxxxxxxx, ea[i]);
  endtask

  initial begin
    bit acked;
    int lat;
    arst_n = 1'b0; grp_req = 1'b0; grp_ch = '0; pt_mode = 1'b0; flush = 1'b0;
    d_rdy = 1'b1; e_rdy = 1'b1; prm_release = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    chk("rst_valid", prm_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_re", {d_re, e_re}, 0);
    chk("rst_adr", {d_adr, e_adr}, 0);
    chk("rst_ack", grp_ack, 0);
    chk("rst_bias", prm_bias, 0);
    chk("rst_quant", prm_quant, 0);
    @(negedge aclk);
    arst_n = 1'b1;
    @(negedge aclk);

    // per-channel, no stalls
    adr_log.delete();
    exp_q.push_back(mk(8, 0));
    req(8, 0, 5, acked);
    chk("t1_ack", acked, 1);
    wait_valid(0, 30, lat);
    chk("t1_latency", lat, 6);
    chk_adrs("t1_adr", 32'h20, 32'h24, 32'h28, 32'h2C, 32'h2C, 5);
    release_one();

    // same with three quant-cache stalls
    adr_log.delete();
    exp_q.push_back(mk(8, 0));
    req(8, 0, 5, acked);
    chk("t2_ack", acked, 1);
    wait_valid(1, 30, lat);
    chk("t2_latency", lat, 9);
    chk_adrs("t2_adr", 32'h20, 32'h24, 32'h28, 32'h2C, 32'h2C, 5);
    release_one();

    // per-tensor broadcast
    adr_log.delete();
    exp_q.push_back(mk(5, 1));
    req(5, 1, 5, acked);
    chk("t4_ack", acked, 1);
    wait_valid(0, 30, lat);
    chk("t4_latency", lat, 3);
    chk_adrs("t4_adr", 32'h14, 32'h14, 0, 0, 0, 2);
    release_one();

    // channel index wraps modulo 2^AW
    adr_log.delete();
    exp_q.push_back(mk(12'hFFE, 0));
    req(12'hFFE, 0, 5, acked);
    chk("t5_ack", acked, 1);
    wait_valid(0, 30, lat);
    chk("t5_latency", lat, 6);
    chk_adrs("t5_adr", 32'h3FF8, 32'h3FFC, 32'h0, 32'h4, 32'h4, 5);
    release_one();

    // both buffers full stalls the third request until a release
    exp_q.push_back(mk(0, 0));
    req(0, 0, 5, acked);
    chk("t3_ack0", acked, 1);
    exp_q.push_back(mk(4, 0));
    req(4, 0, 20, acked);
    chk("t3_ack4", acked, 1);
    exp_q.push_back(mk(8, 0));
    req(8, 0, 14, acked);
    chk("t3_ack8_blocked", acked, 0);
    chk("t3_both_valid", prm_valid, 1);
    release_one();
    req(8, 0, 5, acked);
    chk("t3_ack8_after_release", acked, 1);
    release_one();
    release_one();

    // flush mid-fetch at idx 2, then a fresh group
    exp_q.push_back(mk(20, 0));
    req(20, 0, 5, acked);
    chk("t6_ack20", acked, 1);
    @(negedge aclk);
    @(negedge aclk);
    flush = 1'b1;
    @(negedge aclk);
    flush = 1'b0;
    #1;
    chk("t6_flush_valid", prm_valid, 0);
    chk("t6_flush_busy", busy, 0);
    exp_q.push_back(mk(12, 0));
    req(12, 0, 5, acked);
    chk("t6_ack12", acked, 1);
    wait_valid(0, 30, lat);
    chk("t6_latency", lat, 6);
    release_one();

    // reset mid-fetch
    exp_q.push_back(mk(24, 0));
    req(24, 0, 5, acked);
    chk("t7_ack24", acked, 1);
    @(negedge aclk);
    @(negedge aclk);
    arst_n = 1'b0;
    @(negedge aclk);
    #1;
    chk("t7_rst_valid", prm_valid, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_re", {d_re, e_re}, 0);
    chk("t7_rst_adr", {d_adr, e_adr}, 0);
    chk("t7_rst_ack", grp_ack, 0);
    chk("t7_rst_bias", prm_bias, 0);
    chk("t7_rst_quant", prm_quant, 0);
    @(negedge aclk);
    arst_n = 1'b1;
    @(negedge aclk);
    exp_q.push_back(mk(28, 0));
    req(28, 0, 5, acked);
    chk("t7_ack28", acked, 1);
    wait_valid(0, 30, lat);
    chk("t7_latency", lat, 6);
    release_one();
    repeat (3) @(negedge aclk);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_valid", prm_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
